// File: rtl/axi_mem_responder.sv
// AXI4 slave memory model: word-addressed RAM behind independent read/write burst FSMs.
// Define AXI_SNOOP_EN to issue a MakeInvalid AC snoop after each write burst's B handshake.
module axi_mem_responder #(
  parameter int ID_WIDTH   = 13,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int MEM_WORDS  = 4096,
  localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ID_WIDTH-1:0]   s_axi_awid,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]            s_axi_awlen,
  input  logic [1:0]            s_axi_awburst,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ID_WIDTH-1:0]   s_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [1:0]            s_axi_arburst,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic                  s_axi_acvalid,
  input  logic                  s_axi_acready,
  output logic [ADDR_WIDTH-1:0] s_axi_acaddr,
  output logic [3:0]            s_axi_acsnoop
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int OFF_W = $clog2(STRB_WIDTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP, W_SNOOP} wstate_e;
  typedef enum logic       {R_IDLE, R_DATA} rstate_e;

  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

  // WRAP keeps the bits above the (len+1)-beat window and wraps the bits inside it.
  function automatic logic [ADDR_WIDTH-1:0] beat_next(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [7:0] len,
                                                      input logic [1:0] burst);
    logic [ADDR_WIDTH-1:0] inc, mask;
    inc  = a + ADDR_WIDTH'(STRB_WIDTH);
    mask = (ADDR_WIDTH'(len) << OFF_W) | ADDR_WIDTH'(STRB_WIDTH - 1);
    case (burst)
      BURST_FIXED: return a;
      BURST_WRAP:  return (a & ~mask) | (inc & mask);
      default:     return inc;
    endcase
  endfunction

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  // ---------------- write side ----------------
  wstate_e               w_state_q;
  logic [ADDR_WIDTH-1:0] w_addr_q;
  logic [7:0]            aw_len_q;
  logic [1:0]            aw_burst_q;
  logic                  w_err_q;
  logic [8:0]            w_cnt_q;
  logic                  awready_q, wready_q, bvalid_q;
  logic [ID_WIDTH-1:0]   bid_q;
  logic [1:0]            bresp_q;

  logic             w_fire, mem_we;
  logic [IDX_W-1:0] mem_widx;

  assign w_fire   = (w_state_q == W_DATA) && wready_q && s_axi_wvalid;
  assign mem_we   = w_fire && !w_err_q && (w_cnt_q <= {1'b0, aw_len_q});
  assign mem_widx = w_addr_q[OFF_W +: IDX_W];

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (s_axi_wstrb[b]) mem[mem_widx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
      end
    end
  end

`ifdef AXI_SNOOP_EN
  logic                  acvalid_q;
  logic [ADDR_WIDTH-1:0] acaddr_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_state_q  <= W_IDLE;
      w_addr_q   <= '0;
      aw_len_q   <= '0;
      aw_burst_q <= '0;
      w_err_q    <= 1'b0;
      w_cnt_q    <= '0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bid_q      <= '0;
      bresp_q    <= RESP_OKAY;
`ifdef AXI_SNOOP_EN
      acvalid_q  <= 1'b0;
      acaddr_q   <= '0;
`endif
    end else begin
      case (w_state_q)
        W_IDLE: begin
          if (awready_q && s_axi_awvalid) begin
            bid_q      <= s_axi_awid;
            w_addr_q   <= s_axi_awaddr;
            aw_len_q   <= s_axi_awlen;
            aw_burst_q <= s_axi_awburst;
            w_err_q    <= (s_axi_awburst == BURST_WRAP) && !wrap_len_ok(s_axi_awlen);
            w_cnt_q    <= '0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b1;
            w_state_q  <= W_DATA;
`ifdef AXI_SNOOP_EN
            acaddr_q   <= s_axi_awaddr & ~ADDR_WIDTH'(7'h7F);
`endif
          end else begin
            awready_q <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            w_addr_q <= beat_next(w_addr_q, aw_len_q, aw_burst_q);
            if (w_cnt_q != 9'h1FF) w_cnt_q <= w_cnt_q + 9'd1;
            if (s_axi_wlast) begin
              wready_q  <= 1'b0;
              bvalid_q  <= 1'b1;
              bresp_q   <= (w_err_q || (w_cnt_q != {1'b0, aw_len_q})) ? RESP_SLVERR : RESP_OKAY;
              w_state_q <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            bvalid_q <= 1'b0;
`ifdef AXI_SNOOP_EN
            acvalid_q <= 1'b1;
            w_state_q <= W_SNOOP;
`else
            awready_q <= 1'b1;
            w_state_q <= W_IDLE;
`endif
          end
        end
`ifdef AXI_SNOOP_EN
        W_SNOOP: begin
          if (s_axi_acready) begin
            acvalid_q <= 1'b0;
            awready_q <= 1'b1;
            w_state_q <= W_IDLE;
          end
        end
`endif
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bid     = bid_q;
  assign s_axi_bresp   = bresp_q;

`ifdef AXI_SNOOP_EN
  assign s_axi_acvalid = acvalid_q;
  assign s_axi_acaddr  = acaddr_q;
  assign s_axi_acsnoop = acvalid_q ? 4'b1101 : 4'b0000;
`else
  logic unused_acready;
  assign unused_acready = s_axi_acready;
  assign s_axi_acvalid  = 1'b0;
  assign s_axi_acaddr   = '0;
  assign s_axi_acsnoop  = 4'b0000;
`endif

  // ---------------- read side ----------------
  rstate_e               r_state_q;
  logic [ADDR_WIDTH-1:0] r_addr_q;
  logic [7:0]            ar_len_q;
  logic [1:0]            ar_burst_q;
  logic                  r_err_q;
  logic [7:0]            r_cnt_q;
  logic                  arready_q, rvalid_q, rlast_q;
  logic [ID_WIDTH-1:0]   rid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;

  logic                  ar_err;
  logic [ADDR_WIDTH-1:0] r_addr_nxt;

  assign ar_err     = (s_axi_arburst == BURST_WRAP) && !wrap_len_ok(s_axi_arlen);
  assign r_addr_nxt = beat_next(r_addr_q, ar_len_q, ar_burst_q);

  // rdata is fetched on the edge that advances the beat, so a same-cycle write is seen as old data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state_q  <= R_IDLE;
      r_addr_q   <= '0;
      ar_len_q   <= '0;
      ar_burst_q <= '0;
      r_err_q    <= 1'b0;
      r_cnt_q    <= '0;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
      rid_q      <= '0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          if (arready_q && s_axi_arvalid) begin
            rid_q      <= s_axi_arid;
            r_addr_q   <= s_axi_araddr;
            ar_len_q   <= s_axi_arlen;
            ar_burst_q <= s_axi_arburst;
            r_err_q    <= ar_err;
            r_cnt_q    <= '0;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b1;
            rlast_q    <= (s_axi_arlen == 8'd0);
            rresp_q    <= ar_err ? RESP_SLVERR : RESP_OKAY;
            rdata_q    <= ar_err ? '0 : mem[s_axi_araddr[OFF_W +: IDX_W]];
            r_state_q  <= R_DATA;
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_DATA: begin
          if (s_axi_rready) begin
            if (rlast_q) begin
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              arready_q <= 1'b1;
              r_state_q <= R_IDLE;
            end else begin
              r_addr_q <= r_addr_nxt;
              r_cnt_q  <= r_cnt_q + 8'd1;
              rlast_q  <= ((r_cnt_q + 8'd1) == ar_len_q);
              rdata_q  <= r_err_q ? '0 : mem[r_addr_nxt[OFF_W +: IDX_W]];
            end
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rlast   = rlast_q;
  assign s_axi_rid     = rid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;

endmodule

// File: tb/tb_axi_mem_responder.sv
// Bench for axi_mem_responder: directed vector table, hand sequences, and random bursts vs a memory model.
module tb_axi_mem_responder;
  localparam int MW = 4096;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [12:0] awid = '0, arid = '0, bid, rid;
  logic [63:0] awaddr = '0, araddr = '0, acaddr;
  logic [7:0]  awlen = '0, arlen = '0, wstrb = '0;
  logic [1:0]  awburst = '0, arburst = '0, bresp, rresp;
  logic        awvalid = 0, awready, wlast = 0, wvalid = 0, wready, bvalid, bready = 0;
  logic        arvalid = 0, arready, rlast, rvalid, rready = 0, acvalid, acready = 0;
  logic [63:0] wdata = '0, rdata;
  logic [3:0]  acsnoop;

  axi_mem_responder dut (
    .clk(clk), .reset(rst_n),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awburst(awburst),
    .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
    .s_axi_wready(wready),
    .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arburst(arburst),
    .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .s_axi_acvalid(acvalid), .s_axi_acready(acready), .s_axi_acaddr(acaddr),
    .s_axi_acsnoop(acsnoop)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  logic [63:0] model [MW];
  logic [63:0] wd [256];
  logic [7:0]  ws [256];
  logic [63:0] rd [256];
  logic [1:0]  rr [256];
  logic        rl [256];

  typedef struct {
    bit          wr;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [1:0]  burst;
    int          nbeats;
    logic [7:0]  strb;
    logic [3:0][63:0] d;
    logic [1:0]  resp;
  } vec_t;
  vec_t vec [17];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [63:0] pat(input int w);
    return {32'h5A5A_0000 | 32'(w), 32'(w) * 32'h9E37_79B9};
  endfunction

  function automatic int idx(input logic [63:0] a);
    return int'((a / 64'd8) % 64'(MW));
  endfunction

  function automatic bit wrap_legal(input int len);
    return len == 1 || len == 3 || len == 7 || len == 15;
  endfunction

  // Byte address of beat i, straight from the burst-type definitions.
  function automatic logic [63:0] beat_addr(input logic [63:0] a0, input int len, input int burst, input int i);
    logic [63:0] win, base;
    case (burst)
      0: return a0;
      2: begin
        win  = 64'(len + 1) * 64'd8;
        base = a0 - (a0 % win);
        return base + ((a0 - base + 64'(8 * i)) % win);
      end
      default: return a0 + 64'(8 * i);
    endcase
  endfunction

  function automatic bit sig(input int which);
    case (which)
      0: return awready;
      1: return wready;
      2: return bvalid;
      3: return arready;
      default: return rvalid;
    endcase
  endfunction

  task automatic wait_sig(input int which, input string nm);
    int t = 0;
    while (!sig(which) && t < 200) begin @(posedge clk); #1; t++; end
    if (!sig(which)) begin n_chk++; $display("FAIL %s timeout: got 0 expected 1", nm); end
  endtask

  task automatic do_write(input logic [12:0] id, input logic [63:0] addr, input int len,
                          input int burst, input int nbeats, output logic [1:0] resp);
    bit legal;
    legal = (burst != 2) || wrap_legal(len);
    wait_sig(0, "awready");
    awid = id; awaddr = addr; awlen = 8'(len); awburst = 2'(burst); awvalid = 1;
    @(posedge clk); #1;
    awvalid = 0;
    chk("wready_after_aw", wready, 1);
    for (int i = 0; i < nbeats; i++) begin
      wvalid = 1; wdata = wd[i]; wstrb = ws[i]; wlast = (i == nbeats - 1);
      wait_sig(1, "wready");
      @(posedge clk); #1;
    end
    wvalid = 0; wlast = 0;
    chk("bvalid_after_wlast", bvalid, 1);
    wait_sig(2, "bvalid");
    resp = bresp;
    chk("bid", bid, 64'(id));
    chk("bresp_model", bresp, (!legal || nbeats != len + 1) ? 2 : 0);
    bready = 1;
    @(posedge clk); #1;
    bready = 0;
    for (int i = 0; i < nbeats; i++) begin
      if (legal && i <= len) begin
        int k;
        k = idx(beat_addr(addr, len, burst, i));
        for (int b = 0; b < 8; b++) if (ws[i][b]) model[k][8*b +: 8] = wd[i][8*b +: 8];
      end
    end
  endtask

  task automatic do_read(input logic [12:0] id, input logic [63:0] addr, input int len,
                         input int burst, input logic [31:0] rpat, output int nb);
    int cyc = 0;
    bit held = 0;
    logic [63:0] hd; logic [1:0] hr; logic hl;
    nb = 0;
    wait_sig(3, "arready");
    arid = id; araddr = addr; arlen = 8'(len); arburst = 2'(burst); arvalid = 1;
    @(posedge clk); #1;
    arvalid = 0;
    chk("rvalid_after_ar", rvalid, 1);
    while (nb < len + 1 && cyc < 2000) begin
      rready = rpat[cyc % 32];
      if (held) begin
        chk("rdata_stall", rdata, hd); chk("rlast_stall", rlast, 64'(hl)); chk("rresp_stall", rresp, 64'(hr));
        held = 0;
      end
      if (rvalid && rready) begin
        chk("rid", rid, 64'(id));
        rd[nb] = rdata; rr[nb] = rresp; rl[nb] = rlast; nb++;
      end else if (rvalid) begin
        held = 1; hd = rdata; hr = rresp; hl = rlast;
      end
      @(posedge clk); #1; cyc++;
    end
    rready = 0;
    chk("read_beats", 64'(nb), 64'(len + 1));
    chk("rvalid_after_last", rvalid, 0);
  endtask

  task automatic chk_read_model(input logic [63:0] addr, input int len, input int burst, input int nb);
    bit legal;
    legal = (burst != 2) || wrap_legal(len);
    for (int i = 0; i < nb && i <= len; i++) begin
      chk($sformatf("rd_model_b%0d", i), rd[i], legal ? model[idx(beat_addr(addr, len, burst, i))] : 64'd0);
      chk($sformatf("rresp_model_b%0d", i), rr[i], legal ? 0 : 2);
      chk($sformatf("rlast_model_b%0d", i), rl[i], 64'(i == len));
    end
  endtask

  function automatic vec_t mk(input bit wr, input logic [63:0] addr, input int len, input int burst,
                              input int nb, input logic [7:0] strb, input logic [63:0] d0,
                              input logic [63:0] d1, input logic [63:0] d2, input logic [63:0] d3,
                              input logic [1:0] resp);
    vec_t v;
    v.wr = wr; v.addr = addr; v.len = 8'(len); v.burst = 2'(burst); v.nbeats = nb; v.strb = strb;
    v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3; v.resp = resp;
    return v;
  endfunction

  initial begin
    logic [1:0] resp;
    int nb, len, burst, w, nbeats;
    logic [63:0] addr, old;

`ifdef AXI_SNOOP_EN
    acready = 1;
`endif
    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", awready, 0); chk("rst_arready", arready, 0); chk("rst_wready", wready, 0);
    chk("rst_bvalid", bvalid, 0);   chk("rst_rvalid", rvalid, 0);   chk("rst_rlast", rlast, 0);
    chk("rst_bid", bid, 0);         chk("rst_rid", rid, 0);         chk("rst_rdata", rdata, 0);
    chk("rst_acvalid", acvalid, 0);
    rst_n = 1;
    @(posedge clk); #1;
    chk("awready_after_rst", awready, 1); chk("arready_after_rst", arready, 1);

    // known contents for words 0..255
    for (int blk = 0; blk < 16; blk++) begin
      for (int i = 0; i < 16; i++) begin wd[i] = pat(blk * 16 + i); ws[i] = 8'hFF; end
      do_write(13'(blk), 64'(blk * 128), 15, 1, 16, resp);
    end

    vec[0]  = mk(1, 64'h100, 3, 1, 4, 8'hFF, 1, 2, 3, 4, 0);
    vec[1]  = mk(0, 64'h100, 3, 1, 4, 0, 1, 2, 3, 4, 0);
    vec[2]  = mk(0, 64'h118, 3, 2, 4, 0, 4, 1, 2, 3, 0);
    vec[3]  = mk(1, 64'h0, 0, 1, 1, 8'hFF, 64'h1122_3344_5566_7788, 0, 0, 0, 0);
    vec[4]  = mk(1, 64'h0, 0, 1, 1, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 0);
    vec[5]  = mk(0, 64'h0, 0, 1, 1, 0, 64'h1122_3344_FFFF_FFFF, 0, 0, 0, 0);
    vec[6]  = mk(1, 64'h200, 3, 1, 2, 8'hFF, 64'hA, 64'hB, 0, 0, 2);
    vec[7]  = mk(0, 64'h200, 1, 1, 2, 0, 64'hA, 64'hB, 0, 0, 0);
    vec[8]  = mk(1, 64'h300, 2, 2, 3, 8'hFF, 64'hDEAD, 64'hBEEF, 64'hF00D, 0, 2);
    vec[9]  = mk(0, 64'h300, 0, 1, 1, 0, pat(8'h60), 0, 0, 0, 0);
    vec[10] = mk(0, 64'h300, 2, 2, 3, 0, 0, 0, 0, 0, 2);
    vec[11] = mk(1, 64'h208, 1, 0, 2, 8'hFF, 64'hC, 64'hD, 0, 0, 0);
    vec[12] = mk(0, 64'h208, 1, 0, 2, 0, 64'hD, 64'hD, 0, 0, 0);
    vec[13] = mk(1, 64'h220, 0, 1, 3, 8'hFF, 64'hE, 64'hF, 64'h6, 0, 2);
    vec[14] = mk(0, 64'h220, 1, 1, 2, 0, 64'hE, pat(8'h45), 0, 0, 0);
    vec[15] = mk(0, 64'h0000_0001_0000_8103, 0, 1, 1, 0, 64'd1, 0, 0, 0, 0);
    vec[16] = mk(0, 64'h11C, 1, 2, 2, 0, 64'd4, 64'd3, 0, 0, 0);

    foreach (vec[v]) begin
      if (vec[v].wr) begin
        for (int i = 0; i < vec[v].nbeats; i++) begin wd[i] = vec[v].d[i]; ws[i] = vec[v].strb; end
        do_write(13'(v + 100), vec[v].addr, int'(vec[v].len), int'(vec[v].burst), vec[v].nbeats, resp);
        chk($sformatf("vec%0d_bresp", v), resp, vec[v].resp);
      end else begin
        do_read(13'(v + 200), vec[v].addr, int'(vec[v].len), int'(vec[v].burst), 32'hFFFF_FFFF, nb);
        for (int i = 0; i < nb && i < 4; i++) begin
          chk($sformatf("vec%0d_rdata%0d", v, i), rd[i], vec[v].d[i]);
          chk($sformatf("vec%0d_rresp%0d", v, i), rr[i], vec[v].resp);
          chk($sformatf("vec%0d_rlast%0d", v, i), rl[i], 64'(i == int'(vec[v].len)));
        end
      end
    end

    // rready 1-0-0-1 stall: data held, no beat lost
    do_read(13'h55, 64'h100, 3, 1, 32'hFFFF_FFF9, nb);
    chk_read_model(64'h100, 3, 1, nb);
    for (int i = 0; i < nb; i++) chk($sformatf("stall_beat%0d", i), rd[i], 64'(i + 1));

    // read-first: W and AR to the same word on the same edge
    wait_sig(0, "awready"); wait_sig(3, "arready");
    old = model[idx(64'h500)];
    awaddr = 64'h500; awlen = 0; awburst = 1; awid = 13'h7; awvalid = 1;
    @(posedge clk); #1;
    awvalid = 0;
    wvalid = 1; wdata = 64'hC0FF_EE00_1234_5678; wstrb = 8'hFF; wlast = 1;
    araddr = 64'h500; arlen = 0; arburst = 1; arid = 13'h8; arvalid = 1;
    @(posedge clk); #1;
    wvalid = 0; wlast = 0; arvalid = 0;
    chk("rf_rvalid", rvalid, 1); chk("rf_old_data", rdata, old); chk("rf_bvalid", bvalid, 1);
    rready = 1; bready = 1;
    @(posedge clk); #1;
    rready = 0; bready = 0;
    model[idx(64'h500)] = 64'hC0FF_EE00_1234_5678;
    do_read(13'h9, 64'h500, 0, 1, 32'hFFFF_FFFF, nb);
    chk_read_model(64'h500, 0, 1, nb);

    // simultaneous AW and AR acceptance
    wait_sig(0, "awready"); wait_sig(3, "arready");
    awaddr = 64'h510; awlen = 0; awburst = 1; awid = 13'h11; awvalid = 1;
    araddr = 64'h518; arlen = 0; arburst = 1; arid = 13'h12; arvalid = 1;
    chk("sim_awready", awready, 1); chk("sim_arready", arready, 1);
    @(posedge clk); #1;
    awvalid = 0; arvalid = 0;
    chk("sim_wready", wready, 1); chk("sim_rvalid", rvalid, 1); chk("sim_awready_low", awready, 0);
    chk("sim_rdata", rdata, model[idx(64'h518)]); chk("sim_rlast", rlast, 1);
    wvalid = 1; wdata = 64'h5151; wstrb = 8'hFF; wlast = 1; rready = 1;
    @(posedge clk); #1;
    wvalid = 0; wlast = 0; rready = 0;
    chk("sim_rvalid_drop", rvalid, 0); chk("sim_bvalid", bvalid, 1);
    bready = 1;
    @(posedge clk); #1;
    bready = 0;
    model[idx(64'h510)] = 64'h5151;

    // snoop after write to 0x1238
`ifdef AXI_SNOOP_EN
    acready = 0;
`endif
    wd[0] = 64'h1238; ws[0] = 8'hFF;
    do_write(13'h20, 64'h1238, 0, 1, 1, resp);
`ifdef AXI_SNOOP_EN
    chk("ac_valid", acvalid, 1); chk("ac_addr", acaddr, 64'h1200); chk("ac_snoop", acsnoop, 4'b1101);
    chk("ac_awready_low", awready, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("ac_hold_valid", acvalid, 1); chk("ac_hold_awready", awready, 0);
    acready = 1;
    @(posedge clk); #1;
    chk("ac_done", acvalid, 0); chk("ac_awready_back", awready, 1);
`else
    chk("noac_valid", acvalid, 0); chk("noac_addr", acaddr, 0); chk("noac_snoop", acsnoop, 0);
    chk("noac_awready", awready, 1);
`endif

    // reset in the middle of a write burst; RAM keeps the beats already written
    wait_sig(0, "awready");
    awaddr = 64'h400; awlen = 3; awburst = 1; awid = 13'h30; awvalid = 1;
    @(posedge clk); #1;
    awvalid = 0;
    wvalid = 1; wstrb = 8'hFF; wlast = 0; wdata = 64'hAAAA_0000;
    @(posedge clk); #1;
    wdata = 64'hAAAA_0001;
    @(posedge clk); #1;
    wvalid = 0;
    rst_n = 0;
    #1;
    chk("mid_rst_awready", awready, 0); chk("mid_rst_wready", wready, 0);
    chk("mid_rst_bvalid", bvalid, 0);   chk("mid_rst_arready", arready, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    model[idx(64'h400)] = 64'hAAAA_0000; model[idx(64'h408)] = 64'hAAAA_0001;
    @(posedge clk); #1;
    chk("post_rst_awready", awready, 1); chk("post_rst_arready", arready, 1);
    do_read(13'h31, 64'h400, 3, 1, 32'hFFFF_FFFF, nb);
    chk_read_model(64'h400, 3, 1, nb);

    // random bursts against the model
    for (int it = 0; it < 40; it++) begin
      for (int pass = 0; pass < 2; pass++) begin
        burst = $urandom_range(0, 2);
        if (burst == 2) begin
          len = ($urandom_range(0, 5) == 0) ? ($urandom_range(0, 1) ? 2 : 5) : ((1 << $urandom_range(1, 4)) - 1);
          w = $urandom_range(0, 255);
        end else begin
          len = $urandom_range(0, 15);
          w = $urandom_range(0, 239);
        end
        addr = 64'($urandom_range(0, 3)) * 64'h8000 + 64'(w * 8) + 64'($urandom_range(0, 7));
        if (pass == 0) begin
          nbeats = ($urandom_range(0, 7) == 0) ? $urandom_range(1, len + 3) : len + 1;
          for (int i = 0; i < nbeats; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'($urandom_range(0, 255)); end
          do_write(13'($urandom_range(0, 8191)), addr, len, burst, nbeats, resp);
        end else begin
          do_read(13'($urandom_range(0, 8191)), addr, len, burst, $urandom | 32'h1, nb);
          chk_read_model(addr, len, burst, nb);
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
